// File: rtl/sap_pkg.sv
// Shared SAP definitions: mode encoding and default address width for the MAR.
package sap_pkg;

  localparam int unsigned DEFAULT_ADDR_WIDTH = 8;

  typedef enum logic {
    MODE_RUN  = 1'b0,
    MODE_PROG = 1'b1
  } mar_mode_t;

endpackage

// File: rtl/memory_address_register_v2_if.sv
// MAR bus bundle: control-unit and front-panel inputs plus registered address outputs.
interface memory_address_register_v2_if
  import sap_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) ();

  logic                  Lm_bar;
  logic                  Im;
  logic                  run_not_prog;
  logic [ADDR_WIDTH-1:0] w_bus_in;
  logic [ADDR_WIDTH-1:0] prog_bus_in;
  logic                  prog_load;
  logic                  prog_step;
  logic [ADDR_WIDTH-1:0] out;
  logic                  prog_mode;
  logic                  wrap;

  modport master (
    output Lm_bar, Im, run_not_prog, w_bus_in, prog_bus_in, prog_load, prog_step,
    input  out, prog_mode, wrap
  );

  modport slave (
    input  Lm_bar, Im, run_not_prog, w_bus_in, prog_bus_in, prog_load, prog_step,
    output out, prog_mode, wrap
  );

endinterface

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser for an asynchronous level plus a rising-edge detector on the
// synchronised value. Reset values of the sync chain and history flop are parameters.
module sync_edge_detect #(
  parameter int unsigned STAGES   = 2,
  parameter logic        SYNC_RST = 1'b0,
  parameter logic        HIST_RST = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out,
  output logic rise
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {STAGES{SYNC_RST}};
      hist_q <= HIST_RST;
    end else begin
      sync_q[0] <= async_in;
      for (int i = 1; i < int'(STAGES); i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      hist_q <= sync_q[STAGES-1];
    end
  end

  assign sync_out = sync_q[STAGES-1];
  assign rise     = sync_out & ~hist_q;

endmodule

// File: rtl/memory_address_register_v2.sv
// Memory address register: run-mode load/increment from the control unit, program-mode
// load/step from synchronised front-panel buttons, registered address and wrap pulse.
module memory_address_register_v2
  import sap_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
  input logic                        clk,
  input logic                        rst,
  memory_address_register_v2_if.slave bus
);

  mar_mode_t             state_q;
  mar_mode_t             mode_next_c;
  logic                  mode_change_c;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  wrap_q;
  logic [ADDR_WIDTH:0]   inc_c;

  logic mode_sync;
  logic mode_rise_unused;
  logic load_sync_unused;
  logic load_rise;
  logic step_sync_unused;
  logic step_rise;

  // The mode state register acts as the second synchroniser flop for run_not_prog.
  sync_edge_detect #(.STAGES(1), .SYNC_RST(1'b1), .HIST_RST(1'b1)) u_mode_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (bus.run_not_prog),
    .sync_out (mode_sync),
    .rise     (mode_rise_unused)
  );

  sync_edge_detect #(.STAGES(2), .SYNC_RST(1'b0), .HIST_RST(1'b1)) u_load_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (bus.prog_load),
    .sync_out (load_sync_unused),
    .rise     (load_rise)
  );

  sync_edge_detect #(.STAGES(2), .SYNC_RST(1'b0), .HIST_RST(1'b1)) u_step_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (bus.prog_step),
    .sync_out (step_sync_unused),
    .rise     (step_rise)
  );

  assign mode_next_c   = mode_sync ? MODE_RUN : MODE_PROG;
  assign mode_change_c = (mode_next_c != state_q);
  assign inc_c         = (ADDR_WIDTH+1)'(addr_q) + (ADDR_WIDTH+1)'(1);

  // Mode FSM, address register and wrap flop; a mode-change cycle holds everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MODE_RUN;
      addr_q  <= RESET_ADDR;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= mode_next_c;
      wrap_q  <= 1'b0;
      if (!mode_change_c) begin
        if (state_q == MODE_RUN) begin
          if (!bus.Lm_bar) begin
            addr_q <= bus.w_bus_in;
          end else if (bus.Im) begin
            {wrap_q, addr_q} <= inc_c;
          end
        end else begin
          if (load_rise) begin
            addr_q <= bus.prog_bus_in;
          end else if (step_rise) begin
            {wrap_q, addr_q} <= inc_c;
          end
        end
      end
    end
  end

  assign bus.out       = addr_q;
  assign bus.wrap      = wrap_q;
  assign bus.prog_mode = (state_q == MODE_PROG);

endmodule
